// File: rtl/and_or_arbiter.sv
// and_or_arbiter
//   Round-robin arbiter and sequencer sharing one combinational and_or unit
//   between two requesters. An accepted request registers its operands into
//   the unit's inputs (gnt pulse), captures the unit result one cycle later
//   (done pulse to the owner), then returns to IDLE. One operation per three
//   cycles; ties alternate starting with requester 0.
//
// Ports
//   clock, clear              : clock, asynchronous active-high reset
//   req0/a0/b0/sel0           : requester 0 request and operands
//   req1/a1/b1/sel1           : requester 1 request and operands
//   gnt0/gnt1                 : one-cycle accept pulses (operands sampled)
//   done0/done1               : one-cycle pulses, result_out valid for owner
//   result_out                : captured unit result, held until next capture
//   busy                      : high while in EXEC or RESP
//   alu_A/alu_B/alu_selection : registered inputs driven into the and_or unit
//   alu_result                : combinational result from the and_or unit
module and_or_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             sel0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             sel1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result_out,
    output logic             busy,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic             alu_selection,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       owner;       // 0 = requester 0 owns the in-flight op
    logic       last_grant;  // requester granted most recently
    logic       pick1;       // requester 1 wins arbitration this cycle
    logic       any_req;

    // Requester 1 wins when it is alone, or on a tie when 0 was served last.
    always_comb begin
        any_req = req0 | req1;
        pick1   = req1 & (~req0 | ~last_grant);
    end

    assign busy = (state == EXEC) || (state == RESP);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            result_out    <= '0;
            alu_A         <= '0;
            alu_B         <= '0;
            alu_selection <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        alu_A         <= pick1 ? a1 : a0;
                        alu_B         <= pick1 ? b1 : b0;
                        alu_selection <= pick1 ? sel1 : sel0;
                        owner         <= pick1;
                        last_grant    <= pick1;
                        gnt0          <= ~pick1;
                        gnt1          <= pick1;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    result_out <= alu_result;
                    done0      <= ~owner;
                    done1      <= owner;
                    gnt0       <= 1'b0;
                    gnt1       <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_or_arbiter.sv
// tb_and_or_arbiter
//   Directed bench for and_or_arbiter with an inline and_or unit
//   (selection 1 = bitwise AND, 0 = bitwise OR). Inputs change 1 time unit
//   after the rising edge; outputs are observed at that same point.
module tb_and_or_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clock = 1'b0;
    logic             clear = 1'b0;
    logic             req0 = 1'b0;
    logic [WIDTH-1:0] a0 = '0;
    logic [WIDTH-1:0] b0 = '0;
    logic             sel0 = 1'b0;
    logic             req1 = 1'b0;
    logic [WIDTH-1:0] a1 = '0;
    logic [WIDTH-1:0] b1 = '0;
    logic             sel1 = 1'b0;
    logic             gnt0, gnt1, done0, done1, busy, alu_selection;
    logic [WIDTH-1:0] result_out, alu_A, alu_B, alu_result;

    int checks = 0;
    int errors = 0;

    and_or_arbiter #(.WIDTH(WIDTH)) dut (
        .clock(clock), .clear(clear),
        .req0(req0), .a0(a0), .b0(b0), .sel0(sel0),
        .req1(req1), .a1(a1), .b1(b1), .sel1(sel1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result_out(result_out), .busy(busy),
        .alu_A(alu_A), .alu_B(alu_B), .alu_selection(alu_selection),
        .alu_result(alu_result)
    );

    // and_or unit
    assign alu_result = alu_selection ? (alu_A & alu_B) : (alu_A | alu_B);

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_g0;
        int n_g1;
        int n_grants;
        int last_cyc;
        logic [3:0] order;

        // Reset
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        tick();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_done0", done0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result_out, 0);
        chk("rst_alu_A", alu_A, 0);
        chk("rst_alu_B", alu_B, 0);
        chk("rst_alu_sel", alu_selection, 0);

        // Single request: 7 AND 5 = 5
        req0 = 1'b1; a0 = 7; b0 = 5; sel0 = 1'b1;
        tick();
        chk("single_gnt0", gnt0, 1);
        chk("single_gnt1", gnt1, 0);
        chk("single_alu_A", alu_A, 7);
        chk("single_alu_B", alu_B, 5);
        chk("single_alu_sel", alu_selection, 1);
        chk("single_busy", busy, 1);
        req0 = 1'b0;
        tick();
        chk("single_done0", done0, 1);
        chk("single_done1", done1, 0);
        chk("single_result", result_out, 5);
        chk("single_gnt0_clr", gnt0, 0);
        tick();
        chk("single_done0_clr", done0, 0);
        chk("single_idle", busy, 0);
        chk("single_result_hold", result_out, 5);

        // Tie after reset restores requester 0 priority
        clear = 1'b1;
        tick();
        clear = 1'b0;
        a0 = 6; b0 = 2; sel0 = 1'b0;
        a1 = 32'hF0; b1 = 32'h0F; sel1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        chk("tie_gnt0", gnt0, 1);
        chk("tie_gnt1", gnt1, 0);
        req0 = 1'b0;
        tick();
        chk("tie_done0", done0, 1);
        chk("tie_result0", result_out, 6);
        tick();
        chk("tie_resp_gnt1", gnt1, 0);
        tick();
        chk("tie_gnt1", gnt1, 1);
        chk("tie_alu_A1", alu_A, 32'hF0);
        req1 = 1'b0;
        tick();
        chk("tie_done1", done1, 1);
        chk("tie_done0_off", done0, 0);
        chk("tie_result1", result_out, 0);
        tick();

        // Fairness: last grant was requester 1, so 0 leads
        n_g0 = 0; n_g1 = 0; n_grants = 0; last_cyc = -1; order = '0;
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("fair_gnt_excl", gnt0 & gnt1, 0);
            chk("fair_done_excl", done0 & done1, 0);
            if (gnt0 || gnt1) begin
                if (n_grants < 4) order[3 - n_grants] = gnt1;
                if (last_cyc >= 0) chk("fair_gap", c - last_cyc, 3);
                last_cyc = c;
                n_grants++;
            end
            if (c == 12) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        chk("fair_count", n_grants, 4);
        chk("fair_order", order, 4'b0101);
        tick();
        tick();
        tick();
        chk("fair_idle", busy, 0);

        // Withdrawal during busy and operand change in EXEC: 3 OR C = F
        req0 = 1'b1; a0 = 3; b0 = 32'hC; sel0 = 1'b0;
        tick();
        chk("wd_gnt0", gnt0, 1);
        a0 = 32'hFF;
        req0 = 1'b0;
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
        chk("wd_done0", done0, 1);
        chk("wd_result", result_out, 32'hF);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("wd_no_gnt1", gnt1, 0);
            chk("wd_no_done1", done1, 0);
        end

        // Clear in the EXEC cycle aborts the op
        a0 = 7; b0 = 5; sel0 = 1'b1;
        a1 = 32'h3C; b1 = 32'h0F; sel1 = 1'b1;
        req0 = 1'b1;
        tick();
        chk("mid_gnt0", gnt0, 1);
        req0 = 1'b0;
        req1 = 1'b1;
        clear = 1'b1;
        #1;
        chk("mid_result_clr", result_out, 0);
        chk("mid_busy_clr", busy, 0);
        chk("mid_gnt0_clr", gnt0, 0);
        chk("mid_alu_A_clr", alu_A, 0);
        tick();
        chk("mid_no_done0", done0, 0);
        clear = 1'b0;
        tick();
        chk("mid_gnt1", gnt1, 1);
        chk("mid_no_done0_b", done0, 0);
        req1 = 1'b0;
        tick();
        chk("mid_done1", done1, 1);
        chk("mid_result1", result_out, 32'h0C);
        tick();
        chk("mid_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/and_or_arbiter.md
Name: and_or_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single combinational `and_or` logic unit between two requesters, for example a datapath port and a test/debug port.
- Each accepted request is run as one operation:
  - operands and selection are registered into the unit's inputs;
  - the unit's result is captured;
  - the result is returned to the winning requester with a one-cycle done pulse.
- The block sits between the requesters and the `and_or` instance, and owns that instance's A/B/selection inputs.

Parameters:
- WIDTH, 32, operand/result width; must match the `and_or` unit.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  reset, asynchronous and active-high.
- req0  in  1  requester 0 request; held until gnt0.
- a0  in  WIDTH  requester 0 operand A.
- b0  in  WIDTH  requester 0 operand B.
- sel0  in  1  requester 0 selection.
- req1  in  1  requester 1 request.
- a1  in  WIDTH  requester 1 operand A.
- b1  in  WIDTH  requester 1 operand B.
- sel1  in  1  requester 1 selection.
- gnt0  out  1  one-cycle pulse: requester 0 accepted, operands sampled.
- gnt1  out  1  one-cycle pulse: requester 1 accepted.
- done0  out  1  one-cycle pulse: result_out valid for requester 0.
- done1  out  1  one-cycle pulse: result_out valid for requester 1.
- result_out  out  WIDTH  captured unit result; held until next capture.
- busy  out  1  high in EXEC and RESP.
- alu_A  out  WIDTH  registered operand A to the `and_or` unit.
- alu_B  out  WIDTH  registered operand B to the `and_or` unit.
- alu_selection  out  1  registered selection to the `and_or` unit.
- alu_result  in  WIDTH  combinational result from the `and_or` unit.

Behaviour:
- Reset (clear=1, async):
  - state = IDLE;
  - gnt0/gnt1/done0/done1/busy = 0;
  - alu_A/alu_B/result_out = 0, alu_selection = 0;
  - last_grant = 1, so requester 0 wins the first tie.
- States: IDLE, EXEC, RESP; 2-bit encoding, and undefined encodings return to IDLE.
- IDLE, no request: stay in IDLE; all outputs hold.
- IDLE, one request: accept that requester.
- IDLE, both requests: accept the requester that is not last_grant.
- On accept, at the edge:
  - alu_A/alu_B/alu_selection are loaded from the winner's a/b/sel;
  - owner and last_grant are set to the winner;
  - gnt_winner = 1;
  - state goes to EXEC.
- EXEC (1 cycle):
  - the `and_or` unit settles combinationally;
  - at the edge, result_out is loaded from alu_result, done_owner = 1, gnt cleared, state goes to RESP.
- RESP (1 cycle): done_owner is high; at the edge, done is cleared and state goes to IDLE.
- Latency and throughput:
  - req sampled in cycle N → gnt high in N+1 → done high in N+2, with result_out valid from N+2 until the next capture;
  - throughput is 1 operation per 3 cycles.
- A request that stays high through done is a new request; it is re-arbitrated in the IDLE cycle after RESP.
- Under continuous contention, grants strictly alternate 0,1,0,1.
- Requests during EXEC/RESP are not sampled and not lost while held.
- A request deasserted before its gnt is withdrawn; no operation and no pulse result.
- Operand changes after gnt have no effect on the in-flight operation.
- gnt0 and gnt1 are never high together; the same holds for done0/done1.
- Only the owner receives done.
- clear asserted mid-operation aborts it immediately:
  - no done is issued;
  - result_out returns to 0;
  - after clear deasserts, arbitration restarts with requester 0 priority.
- alu_A/alu_B/alu_selection hold their last values outside EXEC; they change only on accept or clear.

Test Plan:
- Bench instantiates `and_or` with selection 1 = bitwise AND and 0 = bitwise OR.
- Reset: clear=1 for 2 cycles, then 0 → all outputs 0 and busy=0.
- Single request: req0=1, a0=7, b0=5, sel0=1 in cycle N →
  - gnt0=1 in N+1 with alu_A=7, alu_B=5, alu_selection=1;
  - done0=1 in N+2 with result_out=5;
  - done1 never asserted.
- Tie: req0 and req1 rise together; requester 0 carries (a0=6, b0=2, sel0=0), requester 1 carries (a1=0xF0, b1=0x0F, sel1=1) →
  - requester 0 served first: done0 with result_out=6;
  - then requester 1 gnt in the cycle after RESP: done1 with result_out=0.
- Fairness: req0 and req1 held high for 12 cycles → exactly 4 grants, in the order gnt0,gnt1,gnt0,gnt1; every gnt is 3 cycles apart.
- Withdrawal and operand change:
  - req1 pulsed for 1 cycle while busy → no gnt1 and no done1;
  - a0 changed in the EXEC cycle → result_out reflects the value sampled at gnt.
- Reset mid-op: clear=1 in the EXEC cycle of the req0 op (a0=7, b0=5, sel0=1) → no done0, result_out=0, state IDLE; a held req1 is then granted 1 cycle after clear deasserts.
